// File: rtl/mem_imm_unit.sv
// Data memory with a req/ack handshake and programmable wait states, plus a
// registered immediate extender for the accumulator datapath.
module mem_imm_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int IMM_W       = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [1:0]        imm_mode,
  output logic [DATA_W-1:0] imm_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t            state, state_nxt;
  logic [3:0]        wcnt, wcnt_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_IDLE:
        if (req) state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:
        if (wcnt == 4'(WAIT_STATES - 1)) begin
          state_nxt = S_ACCESS;
          wcnt_nxt  = '0;
        end else begin
          wcnt_nxt  = wcnt + 4'd1;
        end
      S_ACCESS:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Request fields are frozen at acceptance so the requester may change them freely.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == S_IDLE && req) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Array is intentionally not reset; a reset before ACCESS never reaches this write.
  always_ff @(posedge CLK) begin
    if (state == S_ACCESS && we_q) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata <= '0;
      ack   <= 1'b0;
    end else begin
      ack <= (state == S_ACCESS);
      if (state == S_ACCESS && !we_q) rdata <= mem[addr_q];
    end
  end

  logic [DATA_W-1:0] imm_sext, imm_nxt;
  assign imm_sext = {{(DATA_W-IMM_W){imm_in[IMM_W-1]}}, imm_in};

  always_comb begin
    imm_nxt = imm_sext;
    case (imm_mode)
      2'b00: imm_nxt = imm_sext;
      2'b01: imm_nxt = {{(DATA_W-IMM_W){1'b0}}, imm_in};
      2'b10: imm_nxt = {imm_in, {(DATA_W-IMM_W){1'b0}}};
      2'b11: imm_nxt = {imm_sext[DATA_W-2:0], 1'b0};
      default: imm_nxt = imm_sext;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) imm_out <= '0;
    else        imm_out <= imm_nxt;
  end

endmodule
